// File: rtl/csa_acc_pkg.sv
// Shared types and sizing for the carry-save accumulator.
// FSM state encoding, default operand/guard widths and the accumulator
// width derivation used by the interface and the datapath.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GUARD = 4;

  // Guard bits sit above the operand so 2^guard operands cannot wrap.
  function automatic int acc_width(input int width, input int guard);
    return width + guard;
  endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand input stream and resolved-total output stream of the
// carry-save accumulator. The slave modport is the accumulator side,
// the master modport is the producer/consumer side.
interface csa_accumulator_if
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GUARD = DEF_GUARD
);
  localparam int ACC_W = acc_width(WIDTH, GUARD);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/csa_accumulator_row.sv
// Row of 3:2 compressors: N independent full-adder cells. The carry
// vector is returned unshifted; the parent aligns it to weight 2^(i+1).

// Single 3:2 full-adder cell.
module csa_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module csa_row #(
  parameter int N = 20
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);
  for (genvar i = 0; i < N; i++) begin : g_cell
    csa_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .c  (c[i]),
      .s  (sum[i]),
      .co (carry[i])
    );
  end
endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator keeping the running total in carry-save form.
// Operands stream in one per cycle; the last operand triggers a single
// carry-propagate add and the total is offered on the output stream.
// Optional feature macro: CSA_ACCUMULATOR_OVF_EN builds a saturating
// operand counter and flags packets longer than 2^GUARD operands.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GUARD = DEF_GUARD
) (
  input logic              clk,
  input logic              rst,
  csa_accumulator_if.slave bus
);
  localparam int ACC_W = acc_width(WIDTH, GUARD);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, c_q;
  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] row_sum, row_carry;
  logic [ACC_W-1:0] sum_q;
  logic             in_ready;
  logic             out_valid;
  logic             accept;

  assign operand = {{GUARD{1'b0}}, bus.in_data};
  assign accept  = bus.in_valid & in_ready;

  csa_row #(.N(ACC_W)) u_row (
    .a     (s_q),
    .b     (c_q),
    .c     (operand),
    .sum   (row_sum),
    .carry (row_carry)
  );

  // Next-state and handshake outputs from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && bus.in_last) state_d = RESOLVE;
      end
      RESOLVE: state_d = OUTPUT;
      OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Carry-save running total: compress on accept, clear once resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c_q <= '0;
    end else if (state_q == ACCUM && accept) begin
      s_q <= row_sum;
      c_q <= row_carry << 1;  // top carry falls off: wraps mod 2^ACC_W
    end else if (state_q == RESOLVE) begin
      s_q <= '0;
      c_q <= '0;
    end
  end

  // Final carry-propagate add, held until the next packet resolves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     sum_q <= '0;
    else if (state_q == RESOLVE) sum_q <= s_q + c_q;
  end

`ifdef CSA_ACCUMULATOR_OVF_EN
  localparam logic [GUARD:0] OVF_LIM = {1'b1, {GUARD{1'b0}}};

  logic [GUARD:0] cnt_q;
  logic           ovf_q;

  // Saturating beat counter and overflow flag captured at resolve time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == ACCUM && accept) begin
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      ovf_q <= 1'b0;
    end else if (state_q == RESOLVE) begin
      ovf_q <= (cnt_q > OVF_LIM);
      cnt_q <= '0;
    end
  end

  assign bus.out_ovf = ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator (WIDTH=16, GUARD=4).
// Expected totals come from plain integer addition of each packet's
// operands; a single compare process checks the output stream every cycle.
module tb_csa_accumulator;
  localparam int WIDTH = 16;
  localparam int GUARD = 4;
  localparam int ACC_W = WIDTH + GUARD;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  bit   prev_hs  = 0;

  csa_accumulator_if #(.WIDTH(WIDTH), .GUARD(GUARD)) bus ();

  csa_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the true integer total reduced mod 2^ACC_W.
  function automatic logic [ACC_W-1:0] model_sum(input logic [WIDTH-1:0] ops[$]);
    longint unsigned t = 0;
    foreach (ops[i]) t += ops[i];
    return t[ACC_W-1:0];
  endfunction

  function automatic logic model_ovf(input int n);
`ifdef CSA_ACCUMULATOR_OVF_EN
    return n > (1 << GUARD);
`else
    return (n < 0);
`endif
  endfunction

  // Output-stream checker: value against the model queue while valid,
  // and the ready/valid state in the cycle following each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_hs = 0;
    end else begin
      if (prev_hs) begin
        check("post_hs_valid", {31'd0, bus.out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, bus.in_ready}, 32'd1);
      end
      if (bus.out_valid) begin
        check("out_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("out_sum", {12'd0, bus.out_sum}, {12'd0, exp_q[0].sum});
          check("out_ovf", {31'd0, bus.out_ovf}, {31'd0, exp_q[0].ovf});
        end
        check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      end
      prev_hs = bus.out_valid && bus.out_ready;
      if (prev_hs && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // Present one beat and return at the edge that accepts it.
  task automatic drive_beat(input logic [WIDTH-1:0] d, input logic last);
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      if (ok) return;
    end
    check("beat_timeout", 32'd1, 32'd0);
  endtask

  task automatic gap();
    bus.in_valid = 1'b0;
    bus.in_data  = WIDTH'($urandom);
    bus.in_last  = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic run_packet(input logic [WIDTH-1:0] ops[$], input int max_gap, input int hold,
                            input bit use_lit, input logic [ACC_W-1:0] lit_sum, input logic lit_ovf);
    exp_t e;
    e.sum = model_sum(ops);
    e.ovf = model_ovf(ops.size());
    exp_q.push_back(e);
    bus.out_ready = 1'b0;
    foreach (ops[i]) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) gap();
      drive_beat(ops[i], i == ops.size() - 1);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("resolve_valid", {31'd0, bus.out_valid}, 32'd0);
    check("resolve_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    if (use_lit) begin
      check("lit_sum", {12'd0, bus.out_sum}, {12'd0, lit_sum});
      check("lit_ovf", {31'd0, bus.out_ovf}, {31'd0, lit_ovf});
    end
    @(posedge clk);
    #1;
    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'($urandom);
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] q[$];
    logic             ovf17;
    exp_t             e;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_sum", {12'd0, bus.out_sum}, 32'd0);
    check("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef CSA_ACCUMULATOR_OVF_EN
    ovf17 = 1'b1;
`else
    ovf17 = 1'b0;
`endif

    // Gap-free 3,5,7.
    q = '{16'd3, 16'd5, 16'd7};
    check("model_357", {12'd0, model_sum(q)}, 32'h0000F);
    run_packet(q, 0, 0, 1, 20'h0000F, 1'b0);

    // 16 and 17 full-scale operands.
    q.delete();
    repeat (16) q.push_back(16'hFFFF);
    check("model_16x", {12'd0, model_sum(q)}, 32'hFFFF0);
    run_packet(q, 0, 0, 1, 20'hFFFF0, 1'b0);
    q.push_back(16'hFFFF);
    check("model_17x", {12'd0, model_sum(q)}, 32'h0FFEF);
    run_packet(q, 0, 0, 1, 20'h0FFEF, ovf17);

    // Single operand behind idle cycles.
    q = '{16'h1234};
    repeat (3) gap();
    run_packet(q, 0, 0, 1, 20'h01234, 1'b0);

    // Backpressure for 5 cycles with junk offered, then a fresh packet.
    q = '{16'h0100, 16'h0023};
    run_packet(q, 0, 5, 1, 20'h00123, 1'b0);
    q = '{16'h0001, 16'h0002};
    run_packet(q, 0, 0, 1, 20'h00003, 1'b0);

    // Reset in the middle of a packet.
    drive_beat(16'd9, 1'b0); #1;
    drive_beat(16'd9, 1'b0); #1;
    bus.in_data = 16'd9;
    #2 rst = 1'b1;
    #1;
    check("mid_pkt_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_pkt_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_pkt_rst_sum", {12'd0, bus.out_sum}, 32'd0);
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a total is being offered.
    e.sum = 20'd3;
    e.ovf = 1'b0;
    exp_q.push_back(e);
    drive_beat(16'd1, 1'b0); #1;
    drive_beat(16'd2, 1'b1); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_out_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_out_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_out_rst_sum", {12'd0, bus.out_sum}, 32'd0);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    q = '{16'd3, 16'd5};
    run_packet(q, 0, 0, 1, 20'd8, 1'b0);

    // Randomized packets against the integer model.
    for (int p = 0; p < 40; p++) begin
      q.delete();
      repeat ($urandom_range(20, 1)) begin
        case ($urandom_range(3, 0))
          0:       q.push_back(16'hFFFF);
          1:       q.push_back(16'h0000);
          default: q.push_back(WIDTH'($urandom));
        endcase
      end
      run_packet(q, $urandom_range(2, 0), $urandom_range(3, 0), 0, '0, 1'b0);
    end

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Multi-operand accumulator that feeds the 3:2 compressor cells of the compressors library. It accepts a packet of WIDTH-bit unsigned operands one per cycle over a valid/ready stream. It keeps the running total in carry-save form (sum vector plus carry vector) using a row of 3:2 compressors. On the last operand it performs one carry-propagate add and presents the resolved total on a valid/ready output.

## Interface
- WIDTH, 16, operand width in bits
- GUARD, 4, guard bits; accumulator width ACC_W = WIDTH+GUARD; up to 2^GUARD operands per packet without overflow
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand present
- in_ready  out  1  block can accept operand
- in_data  in  WIDTH  unsigned operand
- in_last  in  1  marks final operand of packet; qualified by in_valid
- out_valid  out  1  resolved total present
- out_ready  in  1  downstream accepts total
- out_sum  out  ACC_W  packet total, modulo 2^ACC_W
- out_ovf  out  1  packet exceeded 2^GUARD operands (see Configuration)

## Operation
- States: ACCUM, RESOLVE, OUTPUT. Reset state is ACCUM with S=0, C=0.
- ACCUM:
  - in_ready=1.
  - Accept happens when in_valid & in_ready.
  - On accept: {S,C} <= csa(S, C, zero-extended in_data). S is the bitwise XOR of the three inputs. C is the majority of the three inputs shifted left by 1. The bit shifted out of the MSB is dropped (mod 2^ACC_W).
  - On accept with in_last=1: go to RESOLVE. Otherwise stay in ACCUM.
  - in_valid=0 cycles (gaps) leave state unchanged.
- RESOLVE:
  - in_ready=0.
  - out_sum <= S + C, truncated to ACC_W.
  - S, C and the operand counter are cleared. The sticky ovf is kept until the next accept.
  - Go to OUTPUT unconditionally.
- OUTPUT:
  - out_valid=1; out_sum and out_ovf are held stable.
  - On out_valid & out_ready: drop out_valid and go to ACCUM.
- in_data and in_last are ignored whenever in_ready=0.
- A single-operand packet (in_last on the first beat) gives out_sum = in_data.
- The arithmetic is unsigned and wraps modulo 2^ACC_W. No saturation.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, state ACCUM.
- Reset is asynchronous. When asserted mid-packet or mid-OUTPUT, all state is cleared immediately and any partial packet is discarded.
- Throughput: 1 operand/cycle in ACCUM.
- Latency: last beat accepted at edge t; RESOLVE during cycle t..t+1; out_valid=1 after edge t+1.
- Output handshake at edge u: out_valid=0 and in_ready=1 after edge u.
- Minimum per-packet overhead is 2 cycles with in_ready low.
- out_valid never drops without a handshake, except on reset.

## Configuration
- CSA_ACCUMULATOR_OVF_EN defined:
  - An operand counter of width GUARD+1, saturating, counts accepted beats.
  - out_ovf is registered in RESOLVE: 1 if the count is greater than 2^GUARD, else 0.
  - The counter is cleared in RESOLVE.
- Undefined:
  - No counter is built.
  - out_ovf is tied to 0.
  - out_sum behaviour is identical in both cases.

## Structure
- Package csa_acc_pkg holds:
  - state enum typedef (ACCUM, RESOLVE, OUTPUT)
  - default WIDTH/GUARD localparams
  - ACC_W derivation function
- Sub-module csa_row:
  - parameter N
  - ports a, b, c, sum, carry, each N bits
  - built from N library 3:2 full-adder cells
  - purely combinational; the carry shift is done in the parent
- The parent holds the FSM, S/C registers, the final CPA and the optional counter.

## Test plan
All scenarios use WIDTH=16, GUARD=4.
- Reset: assert rst mid-run -> out_valid=0, out_sum=0, in_ready=1 asynchronously. After release, the next packet 3,5 gives 8, with no residue.
- Operands 3,5,7, in_last on 7, gap-free -> out_valid one cycle after the 7 is accepted, out_sum=0x0000F, out_ovf=0.
- 16 × 0xFFFF -> out_sum=0xFFFF0, out_ovf=0.
- 17 × 0xFFFF -> out_sum=0x0FFEF. out_ovf=1 with CSA_ACCUMULATOR_OVF_EN, 0 without it.
- Single operand 0x1234 with in_last, in_valid gaps before it -> out_sum=0x01234.
- Hold out_ready low 5 cycles -> out_valid=1 and out_sum stable, in_ready=0, offered in_data ignored. Handshake -> in_ready=1 on the next cycle, next packet accumulates from 0.
